pip_stage_hs: RTL



---
 rtl/pip_stage_hs.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pip_stage_hs.sv
// -----------------------------------------------------------------------------
// pip_stage_hs -- handshaked pipeline stage register
//
// Sits between two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an
// opaque payload plus a control bundle under a valid/ready handshake.
//
//   SKID = 1 : two-entry skid buffer, in_ready comes straight from a flop so
//              no combinational path runs from out_ready back to in_ready.
//   SKID = 0 : single register, in_ready = !out_valid || out_ready.
//
// A synchronous flush squashes every held entry and wins over a same-cycle
// accept. out_ctrl is forced to zero whenever out_valid is low so a bubble
// can never assert a downstream write enable. A saturating counter records
// cycles in which the stage holds a valid entry that downstream refuses.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_flush      synchronous squash of all held entries
//   i_in_valid   upstream entry valid
//   o_in_ready   stage can accept this cycle
//   i_in_data    upstream payload            [DATA_W]
//   i_in_ctrl    upstream control bundle     [CTRL_W]
//   o_out_valid  downstream entry valid
//   i_out_ready  downstream accepts
//   o_out_data   held payload                [DATA_W]
//   o_out_ctrl   held control, 0 on a bubble [CTRL_W]
//   o_stall_cnt  saturating stall-cycle count [CNT_W]
// -----------------------------------------------------------------------------
module pip_stage_hs #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_main_v;
    logic                w_skid_v;
    logic                w_accept;
    logic                w_consume;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid_in;
    logic                w_stall;
    logic                w_cnt_sat;

    assign w_main_v  = r_state[1];
    assign w_skid_v  = r_state[0];
    assign w_accept  = i_in_valid & o_in_ready;
    assign w_consume = w_main_v & i_out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            // Ready flop tracks the next skid occupancy so it is free of out_ready.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= ~w_state_nxt[0];
                end
            end

            assign o_in_ready = r_in_ready;
        end else begin : g_noskid
            // A same-cycle consume frees the single slot for the incoming entry.
            assign o_in_ready = ~w_main_v | i_out_ready;
        end
    endgenerate

    // Occupancy state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and load selection; flush overrides any accept or consume.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt    = ST_FULL;
                        w_load_skid_in = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can move us.
                    if (w_consume) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Main (output-facing) payload and control register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main_data <= {DATA_W{1'b0}};
            r_main_ctrl <= {CTRL_W{1'b0}};
        end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
        end else if (w_load_main_in) begin
            r_main_data <= i_in_data;
            r_main_ctrl <= i_in_ctrl;
        end
    end

    // Skid register catches the entry accepted while the output is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_data <= {DATA_W{1'b0}};
            r_skid_ctrl <= {CTRL_W{1'b0}};
        end else if (w_load_skid_in) begin
            r_skid_data <= i_in_data;
            r_skid_ctrl <= i_in_ctrl;
        end
    end

    assign w_stall   = w_main_v & ~i_out_ready;
    assign w_cnt_sat = (r_stall_cnt == {CNT_W{1'b1}});

    // Saturating stall counter; only reset clears it, flush does not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_out_valid = w_main_v;
    assign o_out_data  = r_main_data;
    // Bubble gating: a squashed or empty slot presents all-zero control.
    assign o_out_ctrl  = r_main_ctrl & {CTRL_W{w_main_v}};
    assign o_stall_cnt = r_stall_cnt;

    pip_stage_hs_chk #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) u_chk (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_main_v    (w_main_v),
        .i_skid_v    (w_skid_v),
        .i_in_ready  (o_in_ready),
        .i_out_ready (i_out_ready),
        .i_out_data  (o_out_data),
        .i_out_ctrl  (o_out_ctrl),
        .i_stall_cnt (o_stall_cnt)
    );

endmodule

// -----------------------------------------------------------------------------
// pip_stage_hs_chk -- property checker for pip_stage_hs
//
// Observes the stage's occupancy bits and outputs and flags violations of
// the handshake invariants. It drives nothing.
//
// Ports: clock/reset/flush, occupancy bits, ready signals and the outputs.
// -----------------------------------------------------------------------------
module pip_stage_hs_chk #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_main_v,
    input  logic              i_skid_v,
    input  logic              i_in_ready,
    input  logic              i_out_ready,
    input  logic [DATA_W-1:0] i_out_data,
    input  logic [CTRL_W-1:0] i_out_ctrl,
    input  logic [CNT_W-1:0]  i_stall_cnt
);

    // The skid slot is only ever occupied behind an occupied main slot.
    a_skid_behind_main: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_skid_v |-> i_main_v);

    // A full stage never advertises space.
    a_full_not_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_skid_v |-> !i_in_ready);

    // A bubble never carries control bits.
    a_bubble_ctrl_zero: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !i_main_v |-> (i_out_ctrl == {CTRL_W{1'b0}}));

    // A stalled entry stays put until consumed or flushed.
    a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_main_v && !i_out_ready && !i_flush) |=>
            (i_main_v && $stable(i_out_data) && $stable(i_out_ctrl)));

    // Once saturated, the stall counter stays saturated.
    a_cnt_saturates: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_stall_cnt == {CNT_W{1'b1}}) |=> (i_stall_cnt == {CNT_W{1'b1}}));

endmodule
